// File: rtl/pipelined_addsub_pkg.sv
// addsub_pkg: operation encoding and chunk sizing shared by the pipelined adder/subtractor
package addsub_pkg;
  typedef enum logic [1:0] {ADD = 2'd0, ADDC = 2'd1, SUB = 2'd2, SUBB = 2'd3} addsub_op_t;
  function automatic int chunk_of(int width, int stages);
    return width / stages;
  endfunction
endpackage

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand-in and result-out valid/ready channels of the adder/subtractor
interface pipelined_addsub_if #(parameter int WIDTH = 32);
  import addsub_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic carry_in;
  addsub_op_t op;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] sum;
  logic carry_out;
  logic overflow;
  logic zero;
  modport master (
    output in_valid, a, b, carry_in, op, out_ready,
    input in_ready, out_valid, sum, carry_out, overflow, zero
  );
  modport slave (
    input in_valid, a, b, carry_in, op, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_addsub_cla_slice.sv
// cla_slice: combinational W-bit carry-look-ahead adder slice
module cla_slice #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);
  logic [W-1:0] g, p;
  logic [W:0] c;
  function automatic logic [W-1:0] lo(int n);
    return W'((W+1)'(1) << n) - 1'b1;
  endfunction
  assign g = a & b;
  assign p = a ^ b;
  // carry i+1 = cin propagated through p[i:0], or any g[j] propagated through p[i:j+1]
  always_comb begin
    c = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      c[i+1] = cin & (&(p | ~lo(i+1)));
      for (int j = 0; j <= i; j++) c[i+1] = c[i+1] | (g[j] & (&(p | ~lo(i+1) | lo(j+1))));
    end
  end
  assign sum = p ^ c[W-1:0];
  assign cout = c[W];
  assign c_msb_in = c[W-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep chunked add/sub with registered inter-chunk carry and global stall
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int CHUNK = chunk_of(WIDTH, STAGES);
  logic adv, sub, cin;
  logic [WIDTH-1:0] bc;
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_nx [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic cm [STAGES];
  logic [STAGES-1:0] vi, co, zo, v_q, c_q, z_q;
  logic ov_q;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign sub = (bus.op == SUB) || (bus.op == SUBB);
  assign bc = sub ? ~bus.b : bus.b;
  assign cin = bus.op == ADD ? 1'b0 : bus.op == ADDC ? bus.carry_in : bus.op == SUB ? 1'b1 : ~bus.carry_in;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [CHUNK-1:0] ss;
    logic ci, zi;
    if (k == 0) begin : g_first
      assign a_in[k] = bus.a;
      assign b_in[k] = bc;
      assign ci = cin;
      assign zi = 1'b1;
      assign vi[k] = bus.in_valid;
      assign s_nx[k] = WIDTH'(ss);
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign ci = c_q[k-1];
      assign zi = z_q[k-1];
      assign vi[k] = v_q[k-1];
      // completed lower chunks ride along; bits above chunk k are still zero
      assign s_nx[k] = s_q[k-1] | (WIDTH'(ss) << (k*CHUNK));
    end
    cla_slice #(.W(CHUNK)) u_cla (
      .a(a_in[k][k*CHUNK +: CHUNK]),
      .b(b_in[k][k*CHUNK +: CHUNK]),
      .cin(ci),
      .sum(ss),
      .cout(co[k]),
      .c_msb_in(cm[k])
    );
    assign zo[k] = zi & (ss == '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      z_q <= '0;
      ov_q <= 1'b0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      s_q <= '{default: '0};
    end else if (adv) begin
      v_q <= vi;
      c_q <= co;
      z_q <= zo;
      ov_q <= cm[STAGES-1] ^ co[STAGES-1];
      a_q <= a_in;
      b_q <= b_in;
      s_q <= s_nx;
    end
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum = s_q[STAGES-1];
  assign bus.carry_out = c_q[STAGES-1];
  assign bus.overflow = ov_q;
  assign bus.zero = z_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vectors for the 32-bit, 4-stage adder/subtractor
module tb_pipelined_addsub;
  import addsub_pkg::*;
  localparam int WIDTH = 32;
  localparam int STAGES = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();
  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input addsub_op_t op, input logic [31:0] a, input logic [31:0] b, input logic ci, input logic v);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.carry_in = ci;
    bus.in_valid = v;
  endtask
  task automatic run_one(input string tag, input addsub_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [31:0] es, input logic eco, input logic eov, input logic ez);
    drive(op, a, b, ci, 1'b1);
    for (int i = 1; i <= STAGES; i++) begin
      @(negedge clk);
      if (i == 1) bus.in_valid = 1'b0;
      if (i == STAGES - 1) check({tag, ".early"}, bus.out_valid, 1'b0);
    end
    check({tag, ".valid"}, bus.out_valid, 1'b1);
    check({tag, ".sum"}, bus.sum, es);
    check({tag, ".co"}, bus.carry_out, eco);
    check({tag, ".ov"}, bus.overflow, eov);
    check({tag, ".z"}, bus.zero, ez);
    @(negedge clk);
  endtask
  initial begin
    int snt, rcv;
    logic pstall;
    logic [31:0] psum;
    drive(ADD, 32'd0, 32'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.valid_low", bus.out_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.valid", bus.out_valid, 1'b0);
    check("rst.sum", bus.sum, 32'd0);
    check("rst.co", bus.carry_out, 1'b0);
    check("rst.ov", bus.overflow, 1'b0);
    check("rst.z", bus.zero, 1'b0);
    check("rst.in_ready", bus.in_ready, 1'b1);
    run_one("add_ovf", ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_one("add_wrap", ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_one("addc", ADDC, 32'h0, 32'h0, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_one("sub_neg", SUB, 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_one("subb", SUBB, 32'h10, 32'h01, 1'b1, 32'h0000_000E, 1'b1, 1'b0, 1'b0);
    run_one("sub_ovf", SUB, 32'h8000_0000, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_one("sub_eq", SUB, 32'd3, 32'd3, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    run_one("mid_chunk", ADD, 32'h0001_0000, 32'h0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      check($sformatf("tp.valid%0d", c), bus.out_valid, c >= 4 && c < 12);
      if (c >= 4 && c < 12) check($sformatf("tp.sum%0d", c), bus.sum, 64'(2 * (c - 4)));
      drive(ADD, 32'(c), 32'(c), 1'b0, c < 8);
      @(negedge clk);
    end
    snt = 0;
    rcv = 0;
    pstall = 1'b0;
    psum = '0;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      bus.out_ready = !(c >= 5 && c <= 7);
      #1;
      if (pstall) begin
        check($sformatf("bp.hold_valid%0d", c), bus.out_valid, 1'b1);
        check($sformatf("bp.hold_sum%0d", c), bus.sum, psum);
      end
      check($sformatf("bp.in_ready%0d", c), bus.in_ready, !(c >= 5 && c <= 7));
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp.sum%0d", rcv), bus.sum, 64'(2 * rcv));
        rcv++;
      end
      pstall = bus.out_valid && !bus.out_ready;
      psum = bus.sum;
      drive(ADD, 32'(snt), 32'(snt), 1'b0, snt < 8);
      if (bus.in_valid && bus.in_ready) snt++;
      @(negedge clk);
    end
    check("bp.count", 64'(rcv), 64'd8);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp.no_dup%0d", c), bus.out_valid, 1'b0);
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      drive(ADD, 32'(c + 1), 32'(c + 1), 1'b0, c < 3);
      @(negedge clk);
    end
    check("mid.pre_valid", bus.out_valid, 1'b1);
    check("mid.pre_sum", bus.sum, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid.async_valid", bus.out_valid, 1'b0);
    check("mid.async_sum", bus.sum, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("mid.stale%0d", c), bus.out_valid, 1'b0);
    end
    run_one("mid.new", ADD, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
